// File: rtl/fp32_pkg.sv
// Shared FP32 field widths, exponent constants, flag bit positions and operand class type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int MANT_W   = FRAC_W + 1;
    localparam int OEXP_W   = 10;
    localparam int FLAG_W   = 5;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    // Bit positions inside the {nan, inf, zero, ovf, unf} flag vector.
    localparam int FLG_NAN  = 4;
    localparam int FLG_INF  = 3;
    localparam int FLG_ZERO = 2;
    localparam int FLG_OVF  = 1;
    localparam int FLG_UNF  = 0;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic sub;
    } op_class_t;

endpackage

// File: rtl/add8bit.sv
// 8-bit ripple-carry adder with carry in and carry out.
// Latency: combinational.
// Backpressure: not applicable.
module add8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    // Ripple the carry bit by bit from the LSB.
    always_comb begin
        logic w_carry;
        sum     = '0;
        w_carry = cin;
        for (int i = 0; i < 8; i++) begin
            sum[i]  = a[i] ^ b[i] ^ w_carry;
            w_carry = (a[i] & b[i]) | (w_carry & (a[i] ^ b[i]));
        end
        cout = w_carry;
    end

endmodule

// File: rtl/fp32_unpack.sv
// Splits one FP32 operand into sign, effective exponent, {hidden, fraction} and class bits.
// Latency: combinational. Macro FP32_MUL_EXP_FTZ_EN flushes subnormals to zero.
// Backpressure: not applicable.
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]         i_op,
    output logic                o_sign,
    output logic [EXP_W-1:0]    o_exp,
    output logic [MANT_W-1:0]   o_mant,
    output op_class_t           o_cls
);

    logic [EXP_W-1:0]  w_exp;
    logic [FRAC_W-1:0] w_frac;
    logic              w_exp_zero;
    logic              w_exp_ones;
    logic              w_frac_zero;
    logic              w_sub;

    assign o_sign      = i_op[31];
    assign w_exp       = i_op[30:23];
    assign w_frac      = i_op[22:0];
    assign w_exp_zero  = (w_exp == '0);
    assign w_exp_ones  = (w_exp == '1);
    assign w_frac_zero = (w_frac == '0);
    assign w_sub       = w_exp_zero && !w_frac_zero;

    // Classify the operand and form the exponent/mantissa seen by the adder.
    always_comb begin
        o_cls.nan = w_exp_ones && !w_frac_zero;
        o_cls.inf = w_exp_ones && w_frac_zero;
        o_cls.sub = w_sub;
`ifdef FP32_MUL_EXP_FTZ_EN
        // Subnormals behave exactly like a zero operand.
        o_cls.zero = w_exp_zero;
        o_exp      = w_exp;
        o_mant     = w_exp_zero ? '0 : {1'b1, w_frac};
`else
        // Subnormals keep their fraction; their exponent is 1 (effective -126).
        o_cls.zero = w_exp_zero && w_frac_zero;
        o_exp      = w_sub ? EXP_W'(1) : w_exp;
        o_mant     = {!w_exp_zero, w_frac};
`endif
    end

endmodule

// File: rtl/fp32_mul_exp.sv
// FP32 multiplier exponent/classification stage: sign, ea+eb-BIAS, hidden-bit mantissas, flags.
// Latency: 2 cycles, 1 result/cycle. Macro FP32_MUL_EXP_FTZ_EN flushes subnormal inputs to zero.
// Backpressure: valid/ready; in_ready depends only on out_ready and stage valids, full pipe stalls.
module fp32_mul_exp
    import fp32_pkg::*;
#(
    parameter int BIAS = EXP_BIAS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         a,
    input  logic [31:0]         b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_sign,
    output logic [OEXP_W-1:0]   out_exp,
    output logic [MANT_W-1:0]   out_mant_a,
    output logic [MANT_W-1:0]   out_mant_b,
    output logic [FLAG_W-1:0]   out_flags
);

    localparam logic [OEXP_W-1:0] L_BIAS    = OEXP_W'(BIAS);
    localparam logic [OEXP_W-1:0] L_EXP_MAX = OEXP_W'(EXP_MAX);

    // Unpacked operands and exponent sum.
    logic                w_sign_a, w_sign_b;
    logic [EXP_W-1:0]    w_exp_a, w_exp_b;
    logic [MANT_W-1:0]   w_mant_a, w_mant_b;
    op_class_t           w_cls_a, w_cls_b;
    logic [EXP_W-1:0]    w_sum;
    logic                w_cout;

    // Stage 1 state.
    logic                r_s1_valid;
    logic                r_s1_sign;
    logic [EXP_W:0]      r_s1_raw;
    logic [MANT_W-1:0]   r_s1_mant_a, r_s1_mant_b;
    op_class_t           r_s1_cls_a, r_s1_cls_b;

    // Stage 2 state.
    logic                r_s2_valid;
    logic                r_s2_sign;
    logic [OEXP_W-1:0]   r_s2_exp;
    logic [MANT_W-1:0]   r_s2_mant_a, r_s2_mant_b;
    logic [FLAG_W-1:0]   r_s2_flags;

    // Handshake and stage-2 combinational results.
    logic                w_s2_adv, w_s1_adv, w_accept, w_s2_load;
    logic [OEXP_W-1:0]   w_exp;
    logic                w_nan, w_inf, w_zero, w_special;
    logic [FLAG_W-1:0]   w_flags;
    logic                w_unused_sub;

    fp32_unpack u_unpack_a (
        .i_op   (a),
        .o_sign (w_sign_a),
        .o_exp  (w_exp_a),
        .o_mant (w_mant_a),
        .o_cls  (w_cls_a)
    );

    fp32_unpack u_unpack_b (
        .i_op   (b),
        .o_sign (w_sign_b),
        .o_exp  (w_exp_b),
        .o_mant (w_mant_b),
        .o_cls  (w_cls_b)
    );

    add8bit u_add (
        .a    (w_exp_a),
        .b    (w_exp_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // A stage moves when its output slot is free or being drained this cycle.
    assign w_s2_adv  = !r_s2_valid || out_ready;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign w_accept  = in_valid && w_s1_adv;
    assign w_s2_load = w_s2_adv && r_s1_valid;

    // Subnormal class is carried for the downstream view but not needed for flags here.
    assign w_unused_sub = r_s1_cls_a.sub ^ r_s1_cls_b.sub;

    // Unbias: raw sum 0..510 maps to -127..383, needing the full 10 signed bits.
    assign w_exp = {1'b0, r_s1_raw} - L_BIAS;

    // Special-case priority nan > inf > zero; range flags only for ordinary operands.
    always_comb begin
        w_nan     = r_s1_cls_a.nan || r_s1_cls_b.nan ||
                    (r_s1_cls_a.inf && r_s1_cls_b.zero) ||
                    (r_s1_cls_a.zero && r_s1_cls_b.inf);
        w_inf     = (r_s1_cls_a.inf || r_s1_cls_b.inf) && !w_nan;
        w_zero    = (r_s1_cls_a.zero || r_s1_cls_b.zero) && !w_nan && !w_inf;
        w_special = w_nan || w_inf || w_zero;
        w_flags            = '0;
        w_flags[FLG_NAN]   = w_nan;
        w_flags[FLG_INF]   = w_inf;
        w_flags[FLG_ZERO]  = w_zero;
        w_flags[FLG_OVF]   = !w_special && ($signed(w_exp) >= $signed(L_EXP_MAX));
        w_flags[FLG_UNF]   = !w_special && ($signed(w_exp) <= $signed(OEXP_W'(0)));
    end

    // Stage 1: capture unpacked operands and raw exponent sum on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_raw    <= '0;
            r_s1_mant_a <= '0;
            r_s1_mant_b <= '0;
            r_s1_cls_a  <= '0;
            r_s1_cls_b  <= '0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_s1_sign   <= w_sign_a ^ w_sign_b;
                r_s1_raw    <= {w_cout, w_sum};
                r_s1_mant_a <= w_mant_a;
                r_s1_mant_b <= w_mant_b;
                r_s1_cls_a  <= w_cls_a;
                r_s1_cls_b  <= w_cls_b;
            end
        end
    end

    // Stage 2: capture unbiased exponent and flags when stage 1 hands over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid  <= 1'b0;
            r_s2_sign   <= 1'b0;
            r_s2_exp    <= '0;
            r_s2_mant_a <= '0;
            r_s2_mant_b <= '0;
            r_s2_flags  <= '0;
        end else begin
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_load) begin
                r_s2_sign   <= r_s1_sign;
                r_s2_exp    <= w_exp;
                r_s2_mant_a <= r_s1_mant_a;
                r_s2_mant_b <= r_s1_mant_b;
                r_s2_flags  <= w_flags;
            end
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_sign   = r_s2_sign;
    assign out_exp    = r_s2_exp;
    assign out_mant_a = r_s2_mant_a;
    assign out_mant_b = r_s2_mant_b;
    assign out_flags  = r_s2_flags;

endmodule
